// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM of the multicycle MIPS cpu. Every instruction is stepped
// through fetch / decode / execute / memory / writeback. The block drives all
// datapath enables and mux selects.
//
// Ports
//   clk, reset        rising-edge clock; synchronous active-high reset
//   op[5:0]           opcode (instr[31:26]) from the instruction register
//   zero              ALU zero flag, combinational in the same cycle
//   pcen              PC enable = pcwrite | (branch & zero)
//   memwrite          data memory write strobe
//   irwrite           instruction register load (FETCH only)
//   regwrite          register file write
//   iord              memory address select: 0 = PC, 1 = ALUOut
//   memtoreg          writeback select: 0 = ALUOut, 1 = Data
//   regdst            destination select: 0 = rt, 1 = rd
//   alusrca           ALU A select: 0 = PC, 1 = A
//   alusrcb[1:0]      ALU B select: 00 B, 01 4, 10 SignImm, 11 SignImm<<2
//   pcsrc[1:0]        next-PC select: 00 ALUResult, 01 ALUOut, 10 jump target
//   aluop[1:0]        ALU decoder: 00 add, 01 sub, 10 funct
//   state[STATE_W-1:0] current state, for debug
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         op,
   input  logic               zero,
   output logic               pcen,
   output logic               memwrite,
   output logic               irwrite,
   output logic               regwrite,
   output logic               iord,
   output logic               memtoreg,
   output logic               regdst,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [1:0]         aluop,
   output logic [STATE_W-1:0] state
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [STATE_W-1:0] {
      FETCH   = STATE_W'(0),
      DECODE  = STATE_W'(1),
      MEMADR  = STATE_W'(2),
      MEMRD   = STATE_W'(3),
      MEMWB   = STATE_W'(4),
      MEMWR   = STATE_W'(5),
      EXECUTE = STATE_W'(6),
      ALUWB   = STATE_W'(7),
      BRANCH  = STATE_W'(8),
      ADDIEX  = STATE_W'(9),
      ADDIWB  = STATE_W'(10),
      JUMP    = STATE_W'(11)
   } state_t;

   state_t state_q, state_d;
   logic   pcwrite, branch;

   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   assign state = state_q;

   // Next state. op is only looked at in DECODE and MEMADR, where the IR
   // cannot change (irwrite is FETCH-only).
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:   state_d = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
               default:      state_d = FETCH;   // unknown opcode: NOP
            endcase
         end
         MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   state_d = MEMWB;
         EXECUTE: state_d = ALUWB;
         ADDIEX:  state_d = ADDIWB;
         default: state_d = FETCH;              // writebacks, branch, jump, 12-15
      endcase
   end

   // Moore outputs from state; pcen additionally folds in zero.
   always_comb begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      iord     = 1'b0;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      aluop    = 2'b00;
      case (state_q)
         FETCH:   begin irwrite = 1'b1; pcwrite = 1'b1; alusrcb = 2'b01; end
         DECODE:  alusrcb = 2'b11;
         MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
         MEMRD:   iord = 1'b1;
         MEMWB:   begin regwrite = 1'b1; memtoreg = 1'b1; end
         MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
         EXECUTE: begin alusrca = 1'b1; aluop = 2'b10; end
         ALUWB:   begin regwrite = 1'b1; regdst = 1'b1; end
         BRANCH:  begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
         ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
         ADDIWB:  regwrite = 1'b1;
         JUMP:    begin pcwrite = 1'b1; pcsrc = 2'b10; end
         default: ;                             // illegal: everything low
      endcase
      // Reset kills any in-flight write in the same cycle and parks the
      // selects at their FETCH values.
      if (reset) begin
         pcwrite  = 1'b0;
         branch   = 1'b0;
         memwrite = 1'b0;
         irwrite  = 1'b0;
         regwrite = 1'b0;
         iord     = 1'b0;
         memtoreg = 1'b0;
         regdst   = 1'b0;
         alusrca  = 1'b0;
         alusrcb  = 2'b01;
         pcsrc    = 2'b00;
         aluop    = 2'b00;
      end
   end

   assign pcen = pcwrite | (branch & zero);

endmodule
